// File: rtl/moore_seq_detector.sv
// Moore detector for a PAT_W-bit serial pattern (MSB first) with a saturating detection counter.
// Optional MOORE_DET_PROG_EN adds a run-time loadable pattern (pat_load / pat_in).
module moore_seq_detector #(
    parameter int              PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
    parameter bit              OVERLAP = 1'b1,
    parameter int              CNT_W   = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         x,
    input  logic                         x_valid,
    input  logic                         clr_cnt,
`ifdef MOORE_DET_PROG_EN
    input  logic                         pat_load,
    input  logic [PAT_W-1:0]             pat_in,
`endif
    output logic                         y,
    output logic [$clog2(PAT_W+1)-1:0]   state,
    output logic [CNT_W-1:0]             det_cnt,
    output logic                         cnt_sat
);

    localparam int               SW      = $clog2(PAT_W + 1);
    localparam logic [SW-1:0]    S_DET   = SW'(PAT_W);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    if (PAT_W < 2 || PAT_W > 16) begin : g_bad_pat_w
        $error("moore_seq_detector: PAT_W must be in 2..16");
    end

    logic [SW-1:0]    r_state;
    logic [PAT_W-1:0] r_hist;
    logic [CNT_W-1:0] r_cnt;
    logic             r_sat;
    logic [SW-1:0]    w_next;
    logic [SW-1:0]    w_limit;
    logic [PAT_W-1:0] w_hist_next;
    logic [PAT_W-1:0] w_pat;
    logic [PAT_W-1:0] w_seq;
    logic [PAT_W-1:0] w_match;
    logic             w_load;
    logic             w_enter_det;

`ifdef MOORE_DET_PROG_EN
    logic [PAT_W-1:0] r_pat;
    assign w_pat  = r_pat;
    assign w_load = pat_load;
`else
    assign w_pat  = PATTERN;
    assign w_load = 1'b0;
`endif

    // w_match[j-1]: the newest j bits (history plus x) equal the first j pattern bits.
    assign w_seq = {r_hist[PAT_W-2:0], x};
    for (genvar j = 1; j <= PAT_W; j++) begin : g_match
        assign w_match[j-1] = (w_seq[j-1:0] == w_pat[PAT_W-1 -: j]);
    end

    assign w_enter_det = x_valid && !w_load && (w_next == S_DET);

    // State register, bit history, detection counter and (optionally) the active pattern.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= '0;
            r_hist  <= '0;
            r_cnt   <= '0;
            r_sat   <= 1'b0;
`ifdef MOORE_DET_PROG_EN
            r_pat   <= PATTERN;
`endif
        end else begin
            r_state <= w_next;
            r_hist  <= w_hist_next;
            if (clr_cnt) begin
                r_cnt <= '0;
                r_sat <= 1'b0;
            end else if (w_enter_det && r_cnt != CNT_MAX) begin
                r_cnt <= r_cnt + 1'b1;
                if (r_cnt == CNT_MAX - 1'b1) begin
                    r_sat <= 1'b1;
                end
            end
`ifdef MOORE_DET_PROG_EN
            if (pat_load) begin
                r_pat <= pat_in;
            end
`endif
        end
    end

    // Longest pattern prefix that is a suffix of the stream, capped at one more than the current match.
    always_comb begin
        w_limit     = (r_state == S_DET) ? S_DET : r_state + 1'b1;
        w_next      = r_state;
        w_hist_next = r_hist;
        if (w_load) begin
            w_next      = '0;
            w_hist_next = '0;
        end else if (x_valid) begin
            if (r_state == S_DET && !OVERLAP) begin
                w_next      = (x == w_pat[PAT_W-1]) ? SW'(1) : '0;
                w_hist_next = {{(PAT_W-1){1'b0}}, x};
            end else begin
                w_next      = '0;
                w_hist_next = w_seq;
                for (int j = 1; j <= PAT_W; j++) begin
                    if (w_match[j-1] && SW'(j) <= w_limit) begin
                        w_next = SW'(j);
                    end
                end
            end
        end
    end

    always_comb begin
        y       = (r_state == S_DET);
        state   = r_state;
        det_cnt = r_cnt;
        cnt_sat = r_sat;
    end

endmodule

// File: tb/tb_moore_seq_detector.sv
// Bench for moore_seq_detector: three parameterisations driven in lockstep against a reference model.
// Build with MOORE_DET_PROG_EN to also exercise the loadable pattern.
module tb_moore_seq_detector;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       x = 1'b0;
    logic       x_valid = 1'b0;
    logic       clr_cnt = 1'b0;
    logic       pat_load = 1'b0;
    logic [3:0] pat_in = 4'b0000;

    logic       y_ov, sat_ov, y_nov, sat_nov, y_sat, sat_sat;
    logic [2:0] st_ov, st_nov, st_sat;
    logic [7:0] cnt_ov, cnt_nov;
    logic [1:0] cnt_sat2;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] exp_q_ov[$];
    logic [15:0] exp_q_nov[$];
    logic [15:0] exp_q_sat[$];

    // Reference model state, one slot per DUT: 0 overlap, 1 non-overlap, 2 saturating 1111.
    logic [3:0]  m_def[3];
    logic [3:0]  m_pat[3];
    bit          m_ov[3];
    int          m_cmax[3];
    logic [31:0] m_hist[3];
    int          m_n[3];
    int          m_st[3];
    int          m_cnt[3];
    bit          m_sat[3];

    always #5 clk = ~clk;

    moore_seq_detector #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(8)) u_ov (
        .clk(clk), .rst(rst), .x(x), .x_valid(x_valid), .clr_cnt(clr_cnt),
`ifdef MOORE_DET_PROG_EN
        .pat_load(pat_load), .pat_in(pat_in),
`endif
        .y(y_ov), .state(st_ov), .det_cnt(cnt_ov), .cnt_sat(sat_ov)
    );

    moore_seq_detector #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8)) u_nov (
        .clk(clk), .rst(rst), .x(x), .x_valid(x_valid), .clr_cnt(clr_cnt),
`ifdef MOORE_DET_PROG_EN
        .pat_load(pat_load), .pat_in(pat_in),
`endif
        .y(y_nov), .state(st_nov), .det_cnt(cnt_nov), .cnt_sat(sat_nov)
    );

    moore_seq_detector #(.PAT_W(4), .PATTERN(4'b1111), .OVERLAP(1'b1), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .x(x), .x_valid(x_valid), .clr_cnt(clr_cnt),
`ifdef MOORE_DET_PROG_EN
        .pat_load(pat_load), .pat_in(pat_in),
`endif
        .y(y_sat), .state(st_sat), .det_cnt(cnt_sat2), .cnt_sat(sat_sat)
    );

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Brute-force model: longest suffix of the bits since the last restart that is a pattern prefix.
    task automatic model_step(input int i, input logic b, input logic xv, input logic clr,
                              input logic rn, input logic pl, input logic [3:0] pin);
        int j;
        bit det;
        det = 1'b0;
        if (!rn) begin
            m_pat[i]  = m_def[i];
            m_hist[i] = '0;
            m_n[i]    = 0;
            m_st[i]   = 0;
            m_cnt[i]  = 0;
            m_sat[i]  = 1'b0;
        end else begin
            if (pl) begin
                m_pat[i]  = pin;
                m_hist[i] = '0;
                m_n[i]    = 0;
                m_st[i]   = 0;
            end else if (xv) begin
                if (m_st[i] == 4 && !m_ov[i]) m_n[i] = 0;
                m_hist[i] = {m_hist[i][30:0], b};
                if (m_n[i] < 32) m_n[i]++;
                j = 0;
                for (int k = 1; k <= 4; k++) begin
                    if (k <= m_n[i] &&
                        (m_hist[i] & ((32'd1 << k) - 32'd1)) == 32'(m_pat[i] >> (4 - k))) begin
                        j = k;
                    end
                end
                m_st[i] = j;
                det = (j == 4);
            end
            if (clr) begin
                m_cnt[i] = 0;
                m_sat[i] = 1'b0;
            end else if (det && m_cnt[i] < m_cmax[i]) begin
                m_cnt[i]++;
                if (m_cnt[i] == m_cmax[i]) m_sat[i] = 1'b1;
            end
        end
    endtask

    function automatic logic [15:0] model_pack(input int i);
        return {3'b000, 3'(m_st[i]), (m_st[i] == 4), 8'(m_cnt[i]), m_sat[i]};
    endfunction

    task automatic pop_check(input string tag, inout logic [15:0] q[$], input logic [15:0] got);
        if (q.size() == 0) begin
            check_eq({tag, "_empty"}, 16'hdead, 16'h0000);
        end else begin
            check_eq(tag, got, q.pop_front());
        end
    endtask

    // One clock: drive at negedge, push model expectations, compare #1 after the rising edge.
    task automatic step(input logic b, input logic xv, input logic clr, input logic rn, input logic pl);
        @(negedge clk);
        x = b; x_valid = xv; clr_cnt = clr; rst = rn; pat_load = pl;
        for (int i = 0; i < 3; i++) model_step(i, b, xv, clr, rn, pl, pat_in);
        exp_q_ov.push_back(model_pack(0));
        exp_q_nov.push_back(model_pack(1));
        exp_q_sat.push_back(model_pack(2));
        @(posedge clk);
        #1;
        pop_check("sb_ov",  exp_q_ov,  {3'b000, st_ov,  y_ov,  cnt_ov,  sat_ov});
        pop_check("sb_nov", exp_q_nov, {3'b000, st_nov, y_nov, cnt_nov, sat_nov});
        pop_check("sb_sat", exp_q_sat, {3'b000, st_sat, y_sat, 6'b0, cnt_sat2, sat_sat});
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [6:0] t1_bits;
        logic [6:0] t1_y_ov;
        logic [6:0] t1_y_nov;
        int         t4_cnt[7];
        logic       rb, rxv, rclr, rrn, rpl;

        m_def[0] = 4'b1011; m_ov[0] = 1'b1; m_cmax[0] = 255;
        m_def[1] = 4'b1011; m_ov[1] = 1'b0; m_cmax[1] = 255;
        m_def[2] = 4'b1111; m_ov[2] = 1'b1; m_cmax[2] = 3;
        t1_bits  = 7'b1011011;
        t1_y_ov  = 7'b0001001;
        t1_y_nov = 7'b0001000;
        t4_cnt   = '{0, 0, 0, 1, 2, 3, 3};

        // Reset state
        do_reset();
        do_reset();
        check_eq("rst_ov", {3'b000, st_ov, y_ov, cnt_ov, sat_ov}, 16'h0000);

        // T1 / T2: 1,0,1,1,0,1,1
        for (int i = 6; i >= 0; i--) begin
            step(t1_bits[i], 1'b1, 1'b0, 1'b1, 1'b0);
            check_eq("t1_y_ov", 16'(y_ov), 16'(t1_y_ov[i]));
            check_eq("t2_y_nov", 16'(y_nov), 16'(t1_y_nov[i]));
        end
        check_eq("t1_cnt_ov", 16'(cnt_ov), 16'd2);
        check_eq("t2_cnt_nov", 16'(cnt_nov), 16'd1);
        check_eq("t2_state_nov", 16'(st_nov), 16'd1);

        // T3: gap with x_valid=0 mid-pattern and after detection
        do_reset();
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'(i % 2 == 0), 1'b0, 1'b0, 1'b1, 1'b0);
            check_eq("t3_gap_state", 16'(st_ov), 16'd3);
        end
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        check_eq("t3_y_det", 16'(y_ov), 16'd1);
        for (int i = 0; i < 2; i++) begin
            step(1'(i), 1'b0, 1'b0, 1'b1, 1'b0);
            check_eq("t3_y_hold", 16'(y_ov), 16'd1);
        end

        // T4: saturation on the 1111 / CNT_W=2 instance, then clear
        do_reset();
        for (int i = 0; i < 7; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
            check_eq("t4_cnt", 16'(cnt_sat2), 16'(t4_cnt[i]));
        end
        check_eq("t4_sat", 16'(sat_sat), 16'd1);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        check_eq("t4_clr", {14'b0, cnt_sat2}, 16'd0);
        check_eq("t4_clr_sat", 16'(sat_sat), 16'd0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        check_eq("t4_clr_wins", {14'b0, cnt_sat2}, 16'd0);
        check_eq("t4_clr_state", 16'(st_sat), 16'd4);

        // T5: reset mid-pattern discards the partial match
        do_reset();
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("t5_rst_state", 16'(st_ov), 16'd0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        check_eq("t5_after_rst", {12'b0, st_ov, y_ov}, 16'b0010);

`ifdef MOORE_DET_PROG_EN
        // T6: load 0110, detect it, old pattern no longer fires, reset restores 1011
        do_reset();
        pat_in = 4'b0110;
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        check_eq("t6_load_state", 16'(st_ov), 16'd0);
        for (int i = 3; i >= 0; i--) step(pat_in[i], 1'b1, 1'b0, 1'b1, 1'b0);
        check_eq("t6_new_y", 16'(y_ov), 16'd1);
        for (int i = 3; i >= 0; i--) begin
            step(m_def[0][i], 1'b1, 1'b0, 1'b1, 1'b0);
            check_eq("t6_old_no_y", 16'(y_ov), 16'd0);
        end
        do_reset();
        for (int i = 3; i >= 0; i--) step(m_def[0][i], 1'b1, 1'b0, 1'b1, 1'b0);
        check_eq("t6_restored_y", 16'(y_ov), 16'd1);
`endif

        // Random traffic checked by the scoreboard
        do_reset();
        for (int n = 0; n < 400; n++) begin
            rb   = 1'($urandom_range(0, 1));
            rxv  = ($urandom_range(0, 3) != 0);
            rclr = ($urandom_range(0, 31) == 0);
            rrn  = ($urandom_range(0, 63) != 0);
            rpl  = 1'b0;
`ifdef MOORE_DET_PROG_EN
            rpl    = ($urandom_range(0, 39) == 0);
            pat_in = 4'($urandom_range(0, 15));
`endif
            step(rb, rxv, rclr, rrn, rpl);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
